// File: rtl/jtag_avmm_regfile.sv
// Avalon-MM burst slave for the JTAG-to-Avalon master, backed by a
// 32-bit register file with a registered user read port and write strobe.
module jtag_avmm_regfile #(
    parameter int pADDR_WIDTH  = 6,
    parameter int pBURST_WIDTH = 5
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic [31:0]             iADDRESS,
    input  logic                    iREAD,
    input  logic                    iWRITE,
    input  logic [31:0]             iWRITE_DATA,
    input  logic [3:0]              iBYTE_ENABLE,
    input  logic [pBURST_WIDTH-1:0] iBURST_COUNT,
    output logic                    oWAIT_REQUEST,
    output logic [31:0]             oREAD_DATA,
    output logic                    oREAD_DATAVALID,
    input  logic [pADDR_WIDTH-1:0]  iUSR_ADDR,
    output logic [31:0]             oUSR_DATA,
    output logic                    oUSR_WR_STROBE,
    output logic [pADDR_WIDTH-1:0]  oUSR_WR_ADDR
);
    localparam int DEPTH = 1 << pADDR_WIDTH;
    localparam logic [pBURST_WIDTH-1:0] BONE = pBURST_WIDTH'(1);
    localparam logic [pADDR_WIDTH-1:0]  AONE = pADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST
    } state_t;

    state_t                  state_q, state_d;
    logic [pBURST_WIDTH-1:0] remain_q, remain_d;
    logic [pADDR_WIDTH-1:0]  rd_idx_q, rd_idx_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [31:0]             usr_data_q, usr_data_d;
    logic                    wr_strobe_q, wr_strobe_d;
    logic [pADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;

    logic [31:0]             mem [DEPTH];
    logic                    wr_en;
    logic                    mem_we;
    logic [pADDR_WIDTH-1:0]  wr_idx;
    logic [pADDR_WIDTH-1:0]  cmd_idx;
    logic [pBURST_WIDTH-1:0] cmd_beats;
    logic                    unused_addr;

    assign cmd_idx     = iADDRESS[pADDR_WIDTH+1:2];
    assign cmd_beats   = (iBURST_COUNT == '0) ? BONE : iBURST_COUNT;
    assign unused_addr = ^{iADDRESS[31:pADDR_WIDTH+2], iADDRESS[1:0]};
    // A write presented while reset is held must never reach the array.
    assign mem_we      = wr_en & ~iRESET;

    // Next-state, beat counting and read/write data path selection.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        rd_idx_d    = rd_idx_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = wr_addr_q + AONE;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        usr_data_d  = mem[iUSR_ADDR];
        unique case (state_q)
            IDLE: begin
                if (iWRITE) begin
                    // Write has priority; a simultaneous read is dropped.
                    wr_en  = 1'b1;
                    wr_idx = cmd_idx;
                    if (cmd_beats != BONE) begin
                        state_d  = WBURST;
                        remain_d = cmd_beats - BONE;
                    end
                end else if (iREAD) begin
                    rd_data_d  = mem[cmd_idx];
                    rd_valid_d = 1'b1;
                    rd_idx_d   = cmd_idx + AONE;
                    remain_d   = cmd_beats - BONE;
                    state_d    = RBURST;
                end
            end
            WBURST: begin
                if (iWRITE) begin
                    wr_en    = 1'b1;
                    remain_d = remain_q - BONE;
                    if (remain_q == BONE) begin
                        state_d = IDLE;
                    end
                end
            end
            RBURST: begin
                if (remain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rd_data_d  = mem[rd_idx_q];
                    rd_valid_d = 1'b1;
                    rd_idx_d   = rd_idx_q + AONE;
                    remain_d   = remain_q - BONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (wr_en) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = wr_idx;
        end
    end

    // Control and output registers; array contents survive reset.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            rd_idx_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            usr_data_q  <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            rd_idx_q    <= rd_idx_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            usr_data_q  <= usr_data_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    // Byte-masked array write.
    always_ff @(posedge iCLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (iBYTE_ENABLE[b]) begin
                    mem[wr_idx][8*b +: 8] <= iWRITE_DATA[8*b +: 8];
                end
            end
        end
    end

    assign oWAIT_REQUEST   = (state_q == RBURST);
    assign oREAD_DATA      = rd_data_q;
    assign oREAD_DATAVALID = rd_valid_q;
    assign oUSR_DATA       = usr_data_q;
    assign oUSR_WR_STROBE  = wr_strobe_q;
    assign oUSR_WR_ADDR    = wr_addr_q;
endmodule
